// File: rtl/four_and.sv
// four_and: registered quad-input AND with rising-edge pulse and saturating edge count
// Ports: clk, rst_n (async active-low); a..d operands; e = a&b, f = c&d, g = a&b&c&d (registered);
// g_rise pulses in the first cycle g reads 1; g_cnt counts g rising edges, saturating at all-ones.
// FOUR_AND_SYNC_EN: when defined, a..d each pass through a 2-flop synchronizer (latency 3 instead of 1).
module four_and #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  output logic             e,
  output logic             f,
  output logic             g,
  output logic             g_rise,
  output logic [CNT_W-1:0] g_cnt
);
  logic a_s, b_s, c_s, d_s, g_nxt;
`ifdef FOUR_AND_SYNC_EN
  logic [3:0] s1, s2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {a, b, c, d};
      s2 <= s1;
    end
  assign {a_s, b_s, c_s, d_s} = s2;
`else
  assign {a_s, b_s, c_s, d_s} = {a, b, c, d};
`endif
  assign g_nxt = a_s & b_s & c_s & d_s;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      e      <= 1'b0;
      f      <= 1'b0;
      g      <= 1'b0;
      g_rise <= 1'b0;
      g_cnt  <= '0;
    end else begin
      e      <= a_s & b_s;
      f      <= c_s & d_s;
      g      <= g_nxt;
      g_rise <= g_nxt & ~g;
      if (g_rise && !(&g_cnt)) g_cnt <= g_cnt + 1'b1;
    end
endmodule

// File: tb/tb_four_and.sv
// tb_four_and: directed checks of four_and (reset, sweep, async reset, saturation)
module tb_four_and;
`ifdef FOUR_AND_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0, rst_n = 1'b0, a = 1'b1, b = 1'b1, c = 1'b1, d = 1'b1;
  logic e, f, g, g_rise, e2, f2, g2, r2;
  logic [7:0] g_cnt;
  logic [1:0] g_cnt2;
  logic [3:0] h0, h1, h2, h3, cur, prv;
  logic chk_en = 1'b0;
  int checks = 0, errors = 0;
  four_and #(.CNT_W(8)) u8 (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
    .e(e), .f(f), .g(g), .g_rise(g_rise), .g_cnt(g_cnt));
  four_and #(.CNT_W(2)) u2 (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
    .e(e2), .f(f2), .g(g2), .g_rise(r2), .g_cnt(g_cnt2));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  always @(posedge clk or negedge rst_n)
    if (!rst_n) {h0, h1, h2, h3} <= '0;
    else begin
      h0 <= {a, b, c, d};
      h1 <= h0;
      h2 <= h1;
      h3 <= h2;
    end
  assign cur = LAT == 1 ? h0 : h2;
  assign prv = LAT == 1 ? h1 : h3;
  always @(negedge clk)
    if (chk_en && rst_n) begin
      check("e", {31'd0, e}, {31'd0, cur[3] & cur[2]});
      check("f", {31'd0, f}, {31'd0, cur[1] & cur[0]});
      check("g", {31'd0, g}, {31'd0, &cur});
      check("g_rise", {31'd0, g_rise}, {31'd0, &cur & ~&prv});
      check("e2", {31'd0, e2}, {31'd0, cur[3] & cur[2]});
      check("f2", {31'd0, f2}, {31'd0, cur[1] & cur[0]});
      check("g2", {31'd0, g2}, {31'd0, &cur});
      check("g_rise2", {31'd0, r2}, {31'd0, &cur & ~&prv});
    end
  task automatic check_zero(input string tag);
    check({tag, "_e"}, {31'd0, e}, 0);
    check({tag, "_f"}, {31'd0, f}, 0);
    check({tag, "_g"}, {31'd0, g}, 0);
    check({tag, "_rise"}, {31'd0, g_rise}, 0);
    check({tag, "_cnt"}, {24'd0, g_cnt}, 0);
    check({tag, "_cnt2"}, {30'd0, g_cnt2}, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    {a, b, c, d} = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check_zero("rst_hold");
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (LAT) @(negedge clk);
    check("rel_g", {31'd0, g}, 1);
    check("rel_rise", {31'd0, g_rise}, 1);
    check("rel_cnt", {24'd0, g_cnt}, 0);
    @(negedge clk);
    check("rel_rise_off", {31'd0, g_rise}, 0);
    check("rel_cnt1", {24'd0, g_cnt}, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT) @(negedge clk);
    check("arst_g", {31'd0, g}, 1);
    check("arst_rise", {31'd0, g_rise}, 1);
    check("arst_cnt", {24'd0, g_cnt}, 0);
    @(negedge clk);
    check("arst_cnt1", {24'd0, g_cnt}, 1);
    do_reset();
    for (int t = 0; t < 1000; t += 5) begin
      a = 1'((t / 50) & 1);
      b = 1'((t / 100) & 1);
      c = 1'((t / 150) & 1);
      d = 1'((t / 200) & 1);
      #5;
    end
    {a, b, c, d} = 4'b0000;
    repeat (LAT + 2) @(negedge clk);
    check("sweep_cnt", {24'd0, g_cnt}, 1);
    check("sweep_cnt2", {30'd0, g_cnt2}, 1);
    do_reset();
    for (int p = 1; p <= 5; p++) begin
      {a, b, c, d} = 4'b1111;
      repeat (LAT + 1) @(negedge clk);
      {a, b, c, d} = 4'b0000;
      repeat (LAT + 2) @(negedge clk);
      check($sformatf("sat_cnt2_%0d", p), {30'd0, g_cnt2}, p > 3 ? 3 : p);
      check($sformatf("sat_cnt_%0d", p), {24'd0, g_cnt}, p);
    end
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
